// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and write-port type for the scoreboarded register file
package rf_pkg;

    localparam int RF_DATA_W     = 32;
    localparam int RF_ADDR_W     = 4;
    // The write-port struct is sized for the widest supported instance; narrower
    // instances zero-extend into it and truncate back out.
    localparam int RF_MAX_DATA_W = 64;
    localparam int RF_MAX_ADDR_W = 8;

    typedef struct packed {
        logic                     we;
        logic [RF_MAX_ADDR_W-1:0] wa;
        logic [RF_MAX_DATA_W-1:0] wd;
    } wr_port_t;

    function automatic logic wr_hit(input wr_port_t p, input logic [RF_MAX_ADDR_W-1:0] idx);
        return p.we && (p.wa == idx);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-load bits and read-port stall flags
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sb_set,
    input  logic [ADDR_W-1:0]             sb_addr,
    input  logic                          we_b,
    input  logic [ADDR_W-1:0]             wa_b,
    input  logic [NUM_RD-1:0][ADDR_W-1:0] ra,
    output logic [NUM_RD-1:0]             rd_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy;

    // Issue of a new load outranks the return of the previous one to the same index.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sb_set && (sb_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (we_b && (wa_b == ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // A load returning this cycle releases its consumer without waiting for the edge.
    always_comb begin
        rd_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_busy[r] = busy[ra[r]] & ~(we_b && (wa_b == ra[r]));
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - two-write multi-read register file with bypass, scoreboard and output register
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int NUM_RD  = 3,
    parameter int OUT_IDX = 2**ADDR_W-1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we_a,
    input  logic [ADDR_W-1:0]             wa_a,
    input  logic [DATA_W-1:0]             wd_a,
    input  logic                          we_b,
    input  logic [ADDR_W-1:0]             wa_b,
    input  logic [DATA_W-1:0]             wd_b,
    input  logic [NUM_RD-1:0][ADDR_W-1:0] ra,
    output logic [NUM_RD-1:0][DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]             rd_busy,
    input  logic                          sb_set,
    input  logic [ADDR_W-1:0]             sb_addr,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_overrun,
    output logic                          wr_collision
);

    localparam int                       DEPTH = 2**ADDR_W;
    localparam logic [RF_MAX_ADDR_W-1:0] OUT_X = RF_MAX_ADDR_W'(OUT_IDX);

    wr_port_t          port_a;
    wr_port_t          port_b;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              out_wr;
    logic [DATA_W-1:0] out_wd;

    always_comb begin
        port_a    = '0;
        port_a.we = we_a;
        port_a.wa = RF_MAX_ADDR_W'(wa_a);
        port_a.wd = RF_MAX_DATA_W'(wd_a);
        port_b    = '0;
        port_b.we = we_b;
        port_b.wa = RF_MAX_ADDR_W'(wa_b);
        port_b.wd = RF_MAX_DATA_W'(wd_b);
    end

    // Port A has priority wherever both ports hit the same index.
    always_comb begin
        out_wr = wr_hit(port_a, OUT_X) || wr_hit(port_b, OUT_X);
        out_wd = wr_hit(port_a, OUT_X) ? DATA_W'(port_a.wd) : DATA_W'(port_b.wd);
    end

    // The OUT_IDX slot of mem is never written; that index lives in out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i != OUT_IDX) begin
                    if (wr_hit(port_a, RF_MAX_ADDR_W'(i))) begin
                        mem[i] <= DATA_W'(port_a.wd);
                    end else if (wr_hit(port_b, RF_MAX_ADDR_W'(i))) begin
                        mem[i] <= DATA_W'(port_b.wd);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_overrun  <= 1'b0;
            wr_collision <= 1'b0;
        end else begin
            if (out_wr) begin
                out_data  <= out_wd;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    out_overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (we_a && we_b && (wa_a == wa_b)) begin
                wr_collision <= 1'b1;
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (wr_hit(port_a, RF_MAX_ADDR_W'(ra[r]))) begin
                rd[r] = DATA_W'(port_a.wd);
            end else if (wr_hit(port_b, RF_MAX_ADDR_W'(ra[r]))) begin
                rd[r] = DATA_W'(port_b.wd);
            end else if (RF_MAX_ADDR_W'(ra[r]) == OUT_X) begin
                rd[r] = out_data;
            end else begin
                rd[r] = mem[ra[r]];
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .we_b    (we_b),
        .wa_b    (wa_b),
        .ra      (ra),
        .rd_busy (rd_busy)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed and randomized self-checking bench for reg_file_sb
module tb_reg_file_sb;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NR   = 3;
    localparam int OUTI = 15;

    logic               clk = 1'b0;
    logic               rst;
    logic               we_a, we_b, sb_set, out_ready;
    logic [AW-1:0]      wa_a, wa_b, sb_addr;
    logic [DW-1:0]      wd_a, wd_b;
    logic [NR-1:0][AW-1:0] ra;
    logic [NR-1:0][DW-1:0] rd;
    logic [NR-1:0]      rd_busy;
    logic [DW-1:0]      out_data;
    logic               out_valid, out_overrun, wr_collision;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] m_mem [16];
    logic          m_busy [16];
    logic [DW-1:0] m_out;
    logic          m_valid, m_ovr, m_col;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk          (clk),
        .rst          (rst),
        .we_a         (we_a),
        .wa_a         (wa_a),
        .wd_a         (wd_a),
        .we_b         (we_b),
        .wa_b         (wa_b),
        .wd_b         (wd_b),
        .ra           (ra),
        .rd           (rd),
        .rd_busy      (rd_busy),
        .sb_set       (sb_set),
        .sb_addr      (sb_addr),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_overrun  (out_overrun),
        .wr_collision (wr_collision)
    );

    task automatic expect_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int a);
        if (we_a && wa_a == AW'(a)) return wd_a;
        if (we_b && wa_b == AW'(a)) return wd_b;
        if (a == OUTI) return m_out;
        return m_mem[a];
    endfunction

    task automatic idle();
        we_a = 0; wa_a = 0; wd_a = 0;
        we_b = 0; wa_b = 0; wd_b = 0;
        sb_set = 0; sb_addr = 0; out_ready = 0; rst = 0;
        ra = '0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_out = '0; m_valid = 0; m_ovr = 0; m_col = 0;
    endtask

    task automatic m_update();
        logic          ow;
        logic [DW-1:0] od;
        if (rst) begin
            m_reset();
            return;
        end
        if (we_a && we_b && wa_a == wa_b) m_col = 1;
        ow = 0; od = '0;
        if (we_b && int'(wa_b) == OUTI) begin ow = 1; od = wd_b; end
        if (we_a && int'(wa_a) == OUTI) begin ow = 1; od = wd_a; end
        if (ow) begin
            if (m_valid && !out_ready) m_ovr = 1;
            m_out = od;
            m_valid = 1;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (we_b && int'(wa_b) != OUTI) m_mem[wa_b] = wd_b;
        if (we_a && int'(wa_a) != OUTI) m_mem[wa_a] = wd_a;
        if (we_b) m_busy[wa_b] = 1'b0;
        if (sb_set) m_busy[sb_addr] = 1'b1;
    endtask

    // Compare every output against the model mid-cycle, then advance one clock.
    task automatic step();
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            expect_eq($sformatf("rd%0d", r), rd[r], m_read(int'(ra[r])));
            expect_eq($sformatf("rd_busy%0d", r), DW'(rd_busy[r]),
                      DW'(m_busy[ra[r]] && !(we_b && wa_b == ra[r])));
        end
        expect_eq("out_data", out_data, m_out);
        expect_eq("out_valid", DW'(out_valid), DW'(m_valid));
        expect_eq("out_overrun", DW'(out_overrun), DW'(m_ovr));
        expect_eq("wr_collision", DW'(wr_collision), DW'(m_col));
        @(posedge clk);
        m_update();
        #1;
    endtask

    initial begin
        m_reset();
        idle();
        rst = 1;
        #1;
        step();
        step();
        rst = 0;

        // all indices read back zero after reset
        for (int k = 0; k < 16; k += NR) begin
            for (int r = 0; r < NR; r++) ra[r] = AW'((k + r) % 16);
            #1;
            for (int r = 0; r < NR; r++) begin
                expect_eq("rst_rd", rd[r], 32'h0);
                expect_eq("rst_busy", DW'(rd_busy[r]), 32'h0);
            end
            step();
        end
        expect_eq("rst_out_valid", DW'(out_valid), 32'h0);

        // write-first bypass on port A
        idle(); we_a = 1; wa_a = 3; wd_a = 32'hDEADBEEF; ra[0] = 3;
        #1; expect_eq("bypass_a", rd[0], 32'hDEADBEEF);
        step();
        idle(); ra[0] = 3;
        #1; expect_eq("bypass_a_held", rd[0], 32'hDEADBEEF);
        step();

        // same-index collision: A wins, flag sticks
        idle(); we_a = 1; wa_a = 5; wd_a = 32'h11; we_b = 1; wa_b = 5; wd_b = 32'h22;
        step();
        idle(); ra[0] = 5;
        #1;
        expect_eq("collide_data", rd[0], 32'h11);
        expect_eq("collide_flag", DW'(wr_collision), 32'h1);
        step();

        // scoreboard set / load-return release
        idle(); sb_set = 1; sb_addr = 7;
        step();
        idle(); ra[1] = 7;
        #1; expect_eq("sb_busy", DW'(rd_busy[1]), 32'h1);
        step();
        idle(); ra[1] = 7; we_b = 1; wa_b = 7; wd_b = 32'h55;
        #1;
        expect_eq("sb_release", DW'(rd_busy[1]), 32'h0);
        expect_eq("sb_bypass", rd[1], 32'h55);
        step();
        idle(); ra[1] = 7;
        #1; expect_eq("sb_cleared", DW'(rd_busy[1]), 32'h0);
        step();

        // output register overrun and drain
        idle(); we_a = 1; wa_a = AW'(OUTI); wd_a = 32'hA;
        step();
        idle(); we_a = 1; wa_a = AW'(OUTI); wd_a = 32'hB;
        step();
        idle(); ra[2] = AW'(OUTI);
        #1;
        expect_eq("out_last", out_data, 32'hB);
        expect_eq("out_rd", rd[2], 32'hB);
        expect_eq("out_vld", DW'(out_valid), 32'h1);
        expect_eq("out_ovr", DW'(out_overrun), 32'h1);
        out_ready = 1;
        step();
        idle();
        #1; expect_eq("out_drained", DW'(out_valid), 32'h0);
        step();

        // set beats clear; reset wipes busy bits
        idle(); sb_set = 1; sb_addr = 2; we_b = 1; wa_b = 2; wd_b = 32'h77;
        step();
        idle(); ra[2] = 2;
        #1; expect_eq("set_wins", DW'(rd_busy[2]), 32'h1);
        sb_set = 1; sb_addr = 9;
        step();
        idle(); rst = 1; we_a = 1; wa_a = AW'(OUTI); wd_a = 32'h99; sb_set = 1; sb_addr = 4;
        step();
        idle(); ra[0] = 2; ra[1] = 9; ra[2] = 4;
        #1;
        expect_eq("rst_busy2", DW'(rd_busy[0]), 32'h0);
        expect_eq("rst_busy9", DW'(rd_busy[1]), 32'h0);
        expect_eq("rst_busy4", DW'(rd_busy[2]), 32'h0);
        expect_eq("rst_ovr", DW'(out_overrun), 32'h0);
        expect_eq("rst_col", DW'(wr_collision), 32'h0);
        expect_eq("rst_outv", DW'(out_valid), 32'h0);
        step();

        // randomized traffic, biased toward a few indices so hazards are frequent
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst       = ($urandom_range(0, 99) == 0);
            we_a      = $urandom_range(0, 1);
            wa_a      = ($urandom_range(0, 3) == 0) ? AW'(OUTI) : AW'($urandom_range(0, 7));
            wd_a      = $urandom;
            we_b      = $urandom_range(0, 1);
            wa_b      = ($urandom_range(0, 5) == 0) ? AW'(OUTI) : AW'($urandom_range(0, 7));
            wd_b      = $urandom;
            sb_set    = ($urandom_range(0, 2) == 0);
            sb_addr   = AW'($urandom_range(0, 15));
            out_ready = $urandom_range(0, 1);
            for (int r = 0; r < NR; r++) ra[r] = AW'($urandom_range(0, 15));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: register index width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 3: number of read ports.
REQ-004 SHALL have parameter OUT_IDX, default 2**ADDR_W-1: index mapped to the external output register.
REQ-005 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports we_a/wa_a/wd_a  in  1/ADDR_W/DATA_W  ALU write port.
REQ-008 SHALL have ports we_b/wa_b/wd_b  in  1/ADDR_W/DATA_W  load-return write port.
REQ-009 SHALL have ports ra/rd/rd_busy  in/out/out  NUM_RD x ADDR_W / NUM_RD x DATA_W / NUM_RD  read addresses, data, operand-pending flags.
REQ-010 SHALL have ports sb_set/sb_addr  in  1/ADDR_W  mark register pending on load issue.
REQ-011 SHALL have ports out_data/out_valid/out_ready  out/out/in  DATA_W/1/1  output register stream.
REQ-012 SHALL have ports out_overrun/wr_collision  out  1/1  sticky error flags.

Function
REQ-013 Registers 0..depth-1 except OUT_IDX SHALL be plain storage; a write updates the entry on the next rising edge.
REQ-014 Writes to OUT_IDX SHALL load out_data instead of storage and set out_valid the next cycle.
REQ-015 out_valid SHALL clear on a cycle with out_valid & out_ready and no new OUT_IDX write; a simultaneous write keeps out_valid=1 with the new data.
REQ-016 A write to OUT_IDX while out_valid & ~out_ready SHALL overwrite out_data and set out_overrun (sticky until rst).
REQ-017 Both write ports targeting the same index in one cycle: port A SHALL win, and wr_collision SHALL set (sticky until rst).
REQ-018 Reads SHALL be combinational, zero latency; ra[i]==OUT_IDX returns out_data.
REQ-019 Reads SHALL be write-first bypassed: a read matching an active write address returns that cycle's write data (port A over B), including OUT_IDX.
REQ-020 Scoreboard: sb_set SHALL set busy[sb_addr] next cycle; we_b to a busy index SHALL clear it next cycle.
REQ-021 sb_set and we_b to the same index in one cycle: set SHALL win (busy=1).
REQ-022 we_a SHALL NOT change busy bits.
REQ-023 rd_busy[i] SHALL equal busy[ra[i]] & ~(we_b & wa_b==ra[i]) (load-return bypass releases the stall the same cycle).
REQ-024 sb_set to OUT_IDX SHALL be legal and tracked like any index.

Reset
REQ-025 On rst all storage entries, out_data, busy bits SHALL be 0; out_valid, out_overrun, wr_collision SHALL be 0 the cycle after rst.
REQ-026 rst SHALL override all same-cycle writes and sb_set; a pending output word is discarded.
REQ-027 rd/rd_busy during rst SHALL reflect current state plus bypass (no forced value).

Structure
REQ-028 A shared package rf_pkg SHALL hold default DATA_W/ADDR_W constants and the write-port struct type (we, wa, wd).
REQ-029 One sub-module rf_scoreboard SHALL implement busy bits and rd_busy generation; storage, bypass and output register stay in reg_file_sb.

Verification
REQ-030 rst, then read all indices -> rd=0, rd_busy=0, out_valid=0, flags 0.
REQ-031 we_a wa_a=3 wd_a=0xDEADBEEF with ra[0]=3 same cycle -> rd[0]=0xDEADBEEF combinationally; next cycle still 0xDEADBEEF.
REQ-032 we_a and we_b both to 5 (0x11, 0x22) -> reg5=0x11, wr_collision=1.
REQ-033 sb_set addr 7; next cycle ra[1]=7 -> rd_busy[1]=1; we_b wa_b=7 wd_b=0x55 -> rd_busy[1]=0, rd[1]=0x55 same cycle; busy clear after.
REQ-034 out_ready=0, write 0xA to OUT_IDX then 0xB -> out_data=0xB, out_valid=1, out_overrun=1; out_ready=1 one cycle -> out_valid=0.
REQ-035 sb_set and we_b to index 2 same cycle -> busy[2]=1 after edge; rst mid-sequence -> all busy 0 next cycle.
